// File: rtl/interboard_link.sv
// rtl/interboard_link.sv - 4-phase half-duplex chunked message link between boards
module interboard_link #(
    parameter int DATA_W  = 6,
    parameter int MSG_W   = 32,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_en,
    input  logic [MSG_W-1:0]  ctrl_msg,
    output logic              req_out,
    output logic              ack_out,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic              req_in,
    input  logic              ack_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              tx_drop,
    output logic              rx_valid,
    output logic [MSG_W-1:0]  rx_msg,
    output logic              err_timeout
);
    localparam int N     = (MSG_W + DATA_W - 1) / DATA_W;
    localparam int BUF_W = N * DATA_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {T_IDLE, T_SETUP, T_REQ, T_REL, T_DONE} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_REL} rx_state_t;

    tx_state_t         tx_state;
    rx_state_t         rx_state;
    logic              req_s1, req_sync, ack_s1, ack_sync;
    logic [CNT_W-1:0]  tx_idx, rx_cnt;
    logic [BUF_W-1:0]  tx_buf, rx_buf, ctrl_padded;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_run, tmo_hit, tx_accept;

    assign ctrl_padded = BUF_W'(ctrl_msg);
    // One counter watches every handshake wait, including the gap between received chunks
    assign tmo_run = (tx_state == T_REQ) || (tx_state == T_REL) || (rx_state == R_ACK) ||
                     ((rx_state == R_IDLE) && (rx_cnt != '0));
    assign tmo_hit = tmo_run && (tmo_cnt == TMO_LAST);
    assign tx_accept = (tx_state == T_IDLE) && (rx_state == R_IDLE) && (rx_cnt == '0) && !req_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_s1   <= 1'b0;
            req_sync <= 1'b0;
            ack_s1   <= 1'b0;
            ack_sync <= 1'b0;
        end else begin
            req_s1   <= req_in;
            req_sync <= req_s1;
            ack_s1   <= ack_in;
            ack_sync <= ack_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state    <= T_IDLE;
            rx_state    <= R_IDLE;
            tx_idx      <= '0;
            rx_cnt      <= '0;
            tx_buf      <= '0;
            rx_buf      <= '0;
            tmo_cnt     <= '0;
            req_out     <= 1'b0;
            ack_out     <= 1'b0;
            data_out    <= '0;
            data_oe     <= 1'b0;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_drop     <= 1'b0;
            rx_valid    <= 1'b0;
            rx_msg      <= '0;
            err_timeout <= 1'b0;
        end else begin
            tx_done     <= 1'b0;
            tx_drop     <= ctrl_en && !tx_accept;
            rx_valid    <= 1'b0;
            err_timeout <= 1'b0;
            tmo_cnt     <= tmo_run ? tmo_cnt + 1'b1 : '0;

            if (tmo_hit) begin
                tx_state    <= T_IDLE;
                rx_state    <= R_IDLE;
                rx_cnt      <= '0;
                tmo_cnt     <= '0;
                req_out     <= 1'b0;
                ack_out     <= 1'b0;
                data_oe     <= 1'b0;
                tx_busy     <= 1'b0;
                err_timeout <= 1'b1;
            end else begin
                case (tx_state)
                    T_IDLE: if (ctrl_en && tx_accept) begin
                        tx_buf   <= ctrl_padded;
                        tx_idx   <= '0;
                        data_out <= ctrl_padded[DATA_W-1:0];
                        data_oe  <= 1'b1;
                        tx_busy  <= 1'b1;
                        tmo_cnt  <= '0;
                        tx_state <= T_SETUP;
                    end
                    T_SETUP: begin
                        req_out  <= 1'b1;
                        tmo_cnt  <= '0;
                        tx_state <= T_REQ;
                    end
                    T_REQ: if (ack_sync) begin
                        req_out  <= 1'b0;
                        tmo_cnt  <= '0;
                        tx_state <= T_REL;
                    end
                    T_REL: if (!ack_sync) begin
                        tmo_cnt <= '0;
                        if (tx_idx != LAST_CHUNK) begin
                            tx_idx   <= tx_idx + 1'b1;
                            data_out <= tx_buf[(tx_idx + 1) * DATA_W +: DATA_W];
                            tx_state <= T_SETUP;
                        end else begin
                            data_oe  <= 1'b0;
                            tx_done  <= 1'b1;
                            tx_state <= T_DONE;
                        end
                    end
                    T_DONE: begin
                        tx_busy  <= 1'b0;
                        tmo_cnt  <= '0;
                        tx_state <= T_IDLE;
                    end
                    default: tx_state <= T_IDLE;
                endcase

                // A remote request blocks tx_accept, so RX and TX never start together
                case (rx_state)
                    R_IDLE: if (req_sync && (tx_state == T_IDLE)) begin
                        rx_buf[rx_cnt * DATA_W +: DATA_W] <= data_in;
                        ack_out  <= 1'b1;
                        tmo_cnt  <= '0;
                        rx_state <= R_ACK;
                    end
                    R_ACK: if (!req_sync) begin
                        ack_out  <= 1'b0;
                        tmo_cnt  <= '0;
                        rx_state <= R_REL;
                    end
                    R_REL: begin
                        tmo_cnt  <= '0;
                        rx_state <= R_IDLE;
                        if (rx_cnt == LAST_CHUNK) begin
                            rx_msg   <= rx_buf[MSG_W-1:0];
                            rx_valid <= 1'b1;
                            rx_cnt   <= '0;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                    default: rx_state <= R_IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/interboard_link.md
INTERBOARD_LINK -- requirements
Module: interboard_link

Interface
REQ-001 Parameters (name, default, meaning):
  - DATA_W, 6, bits per bus transfer (chunk).
  - MSG_W, 32, message width.
  - TIMEOUT, 1000000, cycle limit for any single handshake wait.
  - N = ceil(MSG_W/DATA_W), derived, chunks per message.
REQ-002 Ports (name, direction, width, meaning):
  - clk, in, 1, system clock.
  - rst, in, 1, synchronous active-high reset.
  - ctrl_en, in, 1, one-cycle pulse requesting transmission of ctrl_msg.
  - ctrl_msg, in, MSG_W, message to send; sampled only on an accepted ctrl_en.
  - req_out, out, 1, local Request line.
  - ack_out, out, 1, local Ack line.
  - data_out, out, DATA_W, local drive value for the shared data bus.
  - data_oe, out, 1, data bus output enable.
  - req_in, in, 1, remote Request, asynchronous.
  - ack_in, in, 1, remote Ack, asynchronous.
  - data_in, in, DATA_W, remote data bus value.
  - tx_busy, out, 1, transmitter not idle.
  - tx_done, out, 1, one-cycle pulse: full message acknowledged.
  - tx_drop, out, 1, one-cycle pulse: ctrl_en rejected.
  - rx_valid, out, 1, one-cycle pulse: rx_msg holds a new message.
  - rx_msg, out, MSG_W, last received message.
  - err_timeout, out, 1, one-cycle pulse: handshake wait exceeded TIMEOUT.

Function
REQ-003 req_in and ack_in SHALL each pass through a 2-flop synchronizer; all protocol decisions SHALL use the synchronized values.
REQ-004 The protocol SHALL be 4-phase and half-duplex; chunk k SHALL be bits [k*DATA_W +: DATA_W], sent LSB chunk first; the bits of the last chunk above MSG_W SHALL be sent as 0.
REQ-005 The TX FSM SHALL have the states T_IDLE, T_SETUP, T_REQ, T_REL, T_DONE.
REQ-006 In T_IDLE, ctrl_en SHALL be accepted only when the RX FSM is in R_IDLE, the RX chunk count is 0 and synced req_in = 0; on acceptance the FSM SHALL latch ctrl_msg, clear the chunk index and go to T_SETUP.
REQ-007 A ctrl_en that is not accepted (TX busy or RX active) SHALL assert tx_drop for one cycle and leave all state unchanged.
REQ-008 In T_SETUP, data_oe = 1 and data_out = current chunk; the FSM SHALL stay for exactly one cycle, then go to T_REQ.
REQ-009 In T_REQ, req_out = 1 and the FSM SHALL wait for synced ack_in = 1, then go to T_REL.
REQ-010 In T_REL, req_out = 0, data_oe stays 1, and the FSM SHALL wait for synced ack_in = 0.
REQ-011 On leaving T_REL, the FSM SHALL go to T_SETUP with index+1 if index < N-1, otherwise to T_DONE.
REQ-012 T_DONE SHALL last one cycle, pulse tx_done, drop data_oe and return to T_IDLE.
REQ-013 Latency: accepted ctrl_en at cycle 0 gives data_oe = 1 at cycle 1 and req_out = 1 at cycle 2.
REQ-014 tx_busy SHALL be 1 in every TX state except T_IDLE.
REQ-015 The RX FSM SHALL have the states R_IDLE, R_ACK, R_REL, with a chunk count 0..N-1.
REQ-016 In R_IDLE, with TX in T_IDLE, synced req_in = 1 SHALL capture data_in into slot [count] of the shift buffer and move to R_ACK.
REQ-017 R_ACK SHALL drive ack_out = 1 and wait for synced req_in = 0, then go to R_REL.
REQ-018 R_REL SHALL drive ack_out = 0 for one cycle, then return to R_IDLE.
REQ-019 On leaving R_REL, if count = N-1: rx_msg SHALL be loaded from the buffer (padding discarded), rx_valid SHALL pulse in the same cycle, and count SHALL wrap to 0; otherwise count SHALL increment.
REQ-020 Timeout: a shared cycle counter SHALL clear on every state change and count while in T_REQ, T_REL or R_ACK, or while RX is in R_IDLE with count > 0.
REQ-021 When the timeout counter reaches TIMEOUT, both FSMs SHALL return to idle, count SHALL clear, req_out/ack_out/data_oe SHALL drop, and err_timeout SHALL pulse for one cycle; tx_done and rx_valid SHALL NOT pulse for the aborted message.
REQ-022 If an accepted ctrl_en and a rising synced req_in occur in the same cycle, RX SHALL win, ctrl_en SHALL be dropped and tx_drop SHALL pulse.

Reset
REQ-023 On rst: both FSMs idle, all counters 0, and all outputs 0 (including rx_msg and the synchronizer flops).
REQ-024 rst mid-transfer SHALL abort the transfer immediately with no done, valid or error pulse.

Verification
REQ-025 Loopback of two instances (A.req_out to B.req_in, and so on), DATA_W = 6, MSG_W = 32, A sends 0xDEADBEEF -> B.rx_valid pulses once with rx_msg = 0xDEADBEEF; A.tx_done pulses after the 6th chunk.
REQ-026 Accepted ctrl_en at cycle 0 -> data_oe = 1 at cycle 1, req_out = 1 at cycle 2, data_out = 0x2F (chunk 0 of 0xDEADBEEF).
REQ-027 ctrl_en pulse while tx_busy = 1 -> tx_drop pulses once; the in-flight message completes unchanged.
REQ-028 TIMEOUT = 16, ack_in held 0 -> err_timeout pulses 16 cycles after entering T_REQ; req_out = 0 and tx_busy = 0 on the next cycle.
REQ-029 Remote sends 3 of 6 chunks, then rst -> no rx_valid; count = 0; a following full message is received correctly.
REQ-030 ctrl_en in the same cycle as a rising synced req_in -> tx_drop pulses, ack_out asserts, and the message is received correctly.
